// File: rtl/adpcm_pkg.sv
// ==== adpcm_pkg : shared types and constants for the ADPCM predictor (rev 1.0) ====
`default_nettype none

package adpcm_pkg;

  localparam int N_ZERO = 6;
  localparam int N_POLE = 2;
  localparam int N_TAPS = N_ZERO + N_POLE;
  localparam int TAP_W  = 3;
  localparam int TMR_W  = 8;

  localparam logic [TAP_W-1:0] TAP_B1        = 3'd0;
  localparam logic [TAP_W-1:0] TAP_LAST_ZERO = 3'(N_ZERO - 1);
  localparam logic [TAP_W-1:0] TAP_A1        = 3'd6;
  localparam logic [TAP_W-1:0] TAP_A2        = 3'(N_TAPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/adap_pred_ack_timer.sv
// ==== adap_pred_ack_timer : loadable down-counter guarding the FMULT handshake (rev 1.0) ====
`default_nettype none

module adap_pred_ack_timer #(
  parameter int               CNT_W    = 8,
  parameter logic [CNT_W-1:0] LOAD_VAL = 8'd16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic dec,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Expiry fires on the last permitted waiting cycle, so the request stays up
  // for exactly LOAD_VAL un-acked cycles.
  assign expire = dec && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/adap_pred_seq.sv
// ==== adap_pred_seq : steps FMULT through 6 zero + 2 pole taps, accumulates SEZ/SE (rev 1.0) ====
`default_nettype none

module adap_pred_seq
  import adpcm_pkg::*;
#(
  parameter int WAN_W       = 16,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_in0,
  input  logic             scan_en,
  output logic             scan_out0,
  input  logic             start,
  input  logic             mul_ack,
  input  logic [WAN_W-1:0] mul_wan,
  output logic             mul_req,
  output logic [2:0]       tap_idx,
  output logic             busy,
  output logic [WAN_W-2:0] sez,
  output logic             sez_valid,
  output logic [WAN_W-2:0] se,
  output logic             se_valid,
  output logic             overrun,
  output logic             timeout
);

  seq_state_e       state_q, state_d;
  logic [WAN_W-1:0] acc_q, acc_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [WAN_W-2:0] sez_q, sez_d;
  logic [WAN_W-2:0] se_q, se_d;
  logic             sez_valid_q, sez_valid_d;
  logic             se_valid_q, se_valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;

  logic [WAN_W-1:0] acc_sum;
  logic             tmr_clear;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_expire;
  logic             unused_scan;

  assign unused_scan = scan_in0 ^ scan_en;

  adap_pred_ack_timer #(
    .CNT_W    (TMR_W),
    .LOAD_VAL (TMR_W'(ACK_TIMEOUT))
  ) u_ack_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .load   (tmr_load),
    .dec    (tmr_dec),
    .expire (tmr_expire)
  );

  // Two's-complement accumulation wraps naturally at WAN_W bits.
  assign acc_sum = acc_q + mul_wan;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    tap_d       = tap_q;
    sez_d       = sez_q;
    se_d        = se_q;
    sez_valid_d = 1'b0;
    se_valid_d  = 1'b0;
    overrun_d   = 1'b0;
    timeout_d   = 1'b0;
    tmr_clear   = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        tap_d = TAP_B1;
        if (start) begin
          state_d  = RUN;
          acc_d    = '0;
          tmr_load = 1'b1;
        end else begin
          state_d   = IDLE;
          tmr_clear = 1'b1;
        end
      end

      RUN: begin
        overrun_d = start;
        if (mul_ack) begin
          acc_d    = acc_sum;
          tmr_load = 1'b1;
          if (tap_q == TAP_LAST_ZERO) begin
            sez_d       = acc_sum[WAN_W-1:1];
            sez_valid_d = 1'b1;
          end
          if (tap_q == TAP_A2) begin
            // SE is captured here so it is presented during the DONE cycle.
            state_d    = DONE;
            tap_d      = TAP_B1;
            se_d       = acc_sum[WAN_W-1:1];
            se_valid_d = 1'b1;
            tmr_clear  = 1'b1;
          end else begin
            tap_d = tap_q + TAP_W'(1);
          end
        end else begin
          tmr_dec = 1'b1;
          if (tmr_expire) begin
            state_d   = IDLE;
            tap_d     = TAP_B1;
            timeout_d = 1'b1;
            tmr_clear = 1'b1;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        tap_d     = TAP_B1;
        tmr_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      tap_q       <= '0;
      sez_q       <= '0;
      se_q        <= '0;
      sez_valid_q <= 1'b0;
      se_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      tap_q       <= tap_d;
      sez_q       <= sez_d;
      se_q        <= se_d;
      sez_valid_q <= sez_valid_d;
      se_valid_q  <= se_valid_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign scan_out0 = 1'b0;
  assign mul_req   = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign tap_idx   = tap_q;
  assign sez       = sez_q;
  assign se        = se_q;
  assign sez_valid = sez_valid_q;
  assign se_valid  = se_valid_q;
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_adap_pred_seq.sv
// ==== tb_adap_pred_seq : scoreboard bench for the adaptive-predictor sequencer (rev 1.0) ====
`default_nettype none

module tb_adap_pred_seq;

  localparam int WAN_W       = 16;
  localparam int ACK_TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             scan_in0 = 1'b0;
  logic             scan_en = 1'b0;
  logic             scan_out0;
  logic             start = 1'b0;
  logic             mul_ack = 1'b0;
  logic [WAN_W-1:0] mul_wan = '0;
  logic             mul_req;
  logic [2:0]       tap_idx;
  logic             busy;
  logic [WAN_W-2:0] sez;
  logic             sez_valid;
  logic [WAN_W-2:0] se;
  logic             se_valid;
  logic             overrun;
  logic             timeout;

  adap_pred_seq #(.WAN_W(WAN_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .scan_in0  (scan_in0),
    .scan_en   (scan_en),
    .scan_out0 (scan_out0),
    .start     (start),
    .mul_ack   (mul_ack),
    .mul_wan   (mul_wan),
    .mul_req   (mul_req),
    .tap_idx   (tap_idx),
    .busy      (busy),
    .sez       (sez),
    .sez_valid (sez_valid),
    .se        (se),
    .se_valid  (se_valid),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // cyc == n from rising edge n until edge n+1; cycle "k+n" of the latency
  // table is the clock period that ends at edge k+n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t q_sez[$];
  exp_t q_se[$];
  exp_t q_ov[$];
  exp_t q_to[$];

  int n_chk  = 0;
  int n_fail = 0;
  int last_sez = 0;
  int last_se  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input int kind, input logic [63:0] act);
    exp_t  e;
    string nm;
    bit    empty;
    empty = 1'b0;
    e     = '{0, -1};
    case (kind)
      0: begin nm = "sez";     empty = (q_sez.size() == 0); if (!empty) e = q_sez.pop_front(); end
      1: begin nm = "se";      empty = (q_se.size() == 0);  if (!empty) e = q_se.pop_front();  end
      2: begin nm = "overrun"; empty = (q_ov.size() == 0);  if (!empty) e = q_ov.pop_front();  end
      default: begin nm = "timeout"; empty = (q_to.size() == 0); if (!empty) e = q_to.pop_front(); end
    endcase
    if (empty) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_unexpected: pulse with nothing pending, got 0x%0h (t=%0t)", nm, act, $time);
    end else begin
      chk(nm, act, 64'(e.val));
      if (e.cyc >= 0) chk({nm, "_cycle"}, 64'(cyc), 64'(e.cyc));
    end
  endtask

  // Monitor: pops the scoreboard on every output pulse and checks tap hold.
  logic       prev_stall = 1'b0;
  logic [2:0] prev_tap = '0;
  always @(negedge clk) begin
    if (reset) begin
      if (sez_valid) sb_pop(0, 64'(sez));
      if (se_valid)  sb_pop(1, 64'(se));
      if (overrun)   sb_pop(2, 64'd1);
      if (timeout)   sb_pop(3, 64'd1);
      if (prev_stall && mul_req) chk("tap_hold", 64'(tap_idx), 64'(prev_tap));
    end
    prev_stall = reset && mul_req && !mul_ack;
    prev_tap   = tap_idx;
  end

  task automatic chk_all_zero(input string name);
    chk(name, {mul_req, tap_idx, busy, sez, se, sez_valid, se_valid, overrun, timeout, scan_out0},
        '0);
  endtask

  // Runs one sequence. dly[i] idle cycles precede the ack for tap i; to_tap
  // (if 0..7) withholds that ack until the timeout; ov_tap (if 0..7) pulses
  // start alongside that tap's ack.
  task automatic do_seq(input logic [15:0] w[8], input int dly[8], input int to_tap,
                        input int ov_tap, input bit timed);
    int k;
    int sum;
    k   = cyc + 1;
    sum = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == to_tap) begin
        q_to.push_back('{1, cyc + ACK_TIMEOUT});
        repeat (ACK_TIMEOUT) begin
          chk("req_while_stalled", 64'(mul_req), 64'd1);
          @(posedge clk); #1;
        end
        chk("req_after_timeout", 64'(mul_req), 64'd0);
        chk("busy_after_timeout", 64'(busy), 64'd0);
        chk("sez_kept_after_timeout", 64'(sez), 64'(last_sez));
        chk("se_kept_after_timeout", 64'(se), 64'(last_se));
        return;
      end
      for (int d = 0; d < dly[i]; d++) begin
        @(posedge clk); #1;
      end
      chk("tap_idx", 64'(tap_idx), 64'(i));
      chk("busy_run", 64'(busy), 64'd1);
      mul_ack = 1'b1;
      mul_wan = w[i];
      if (i == ov_tap) begin
        start = 1'b1;
        q_ov.push_back('{1, cyc + 1});
      end
      sum += int'(w[i]);
      if (i == 5) begin
        last_sez = (sum & 32'hFFFF) >> 1;
        q_sez.push_back('{last_sez, timed ? k + 6 : -1});
      end
      if (i == 7) begin
        last_se = (sum & 32'hFFFF) >> 1;
        q_se.push_back('{last_se, timed ? k + 8 : -1});
      end
      @(posedge clk); #1;
      mul_ack = 1'b0;
      start   = 1'b0;
    end
    chk("busy_done", 64'(busy), 64'd0);
    chk("req_done", 64'(mul_req), 64'd0);
    chk("tap_done", 64'(tap_idx), 64'd0);
  endtask

  logic [15:0] w_nom[8];
  logic [15:0] w_wrap[8];
  logic [15:0] w_rnd[8];
  int          d_zero[8];
  int          d_rnd[8];

  initial begin
    w_nom  = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0100, 16'hFFFE};
    w_wrap = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
    d_zero = '{0, 0, 0, 0, 0, 0, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    reset = 1'b1;
    @(posedge clk); #1;

    // Nominal, then wrap-around without saturation.
    do_seq(w_nom, d_zero, -1, -1, 1'b1);
    chk("sez_nominal_value", 64'(last_sez), 64'h000A);
    chk("se_nominal_value", 64'(last_se), 64'h0089);
    repeat (2) @(posedge clk); #1;
    do_seq(w_wrap, d_zero, -1, -1, 1'b1);
    repeat (2) @(posedge clk); #1;

    // Stalled handshake with random ack delays.
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 8; i++) d_rnd[i] = int'($urandom_range(0, 5));
      do_seq(w_nom, d_rnd, -1, -1, 1'b0);
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
      #1;
    end

    // Random products, ack tied high.
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 8; i++) w_rnd[i] = 16'($urandom);
      do_seq(w_rnd, d_zero, -1, -1, 1'b1);
      @(posedge clk); #1;
    end

    // Timeout on the first pole tap, then a normal sequence.
    do_seq(w_nom, d_zero, 6, -1, 1'b1);
    @(posedge clk); #1;
    do_seq(w_nom, d_zero, -1, -1, 1'b1);

    // Overrun at k+3, and a start taken during DONE.
    do_seq(w_nom, d_zero, -1, 2, 1'b1);
    do_seq(w_wrap, d_zero, -1, -1, 1'b1);
    repeat (2) @(posedge clk); #1;

    // Reset mid-sequence.
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    mul_ack = 1'b1;
    mul_wan = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("reset_mid_op");
    mul_ack  = 1'b0;
    reset    = 1'b1;
    last_sez = 0;
    last_se  = 0;
    @(posedge clk); #1;
    do_seq(w_nom, d_zero, -1, -1, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    chk("pending_expectations", 64'(q_sez.size() + q_se.size() + q_ov.size() + q_to.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got t=%0t", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
